median_frame_sink: RTL and testbench

//  Receive end of the median filter pixel stream. It counts pixels entering the filter and discards
//  the 2*WIDTH+2 warm-up outputs. The remaining valid filter outputs go into an on-chip frame store.
//  The block then drains the store through a valid/ready read port and reports the frame's cycle count.

---
 rtl/median_frame_sink.sv | 136 +++++++++++++
 tb/tb_median_frame_sink.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_frame_sink.sv
// median_frame_sink: receive end of the median filter stream.
// Skips the filter warm-up outputs, stores the remaining pixels of a frame in
// an on-chip store, then drains them through a valid/ready port while holding
// the frame's cycle count.
module median_frame_sink #(
  parameter int WIDTH   = 256,
  parameter int HEIGHT  = 256,
  parameter int LAT     = 2*WIDTH+2,
  parameter int TOTAL   = WIDTH*HEIGHT,
  parameter int OUT_PIX = TOTAL-LAT,
  parameter int AW      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  pixel_in,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic        busy,
  output logic        done,
  output logic [31:0] cycle_cnt
);

  localparam int CW = $clog2(TOTAL+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SKIP  = 2'd1;
  localparam logic [1:0] CAPT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [CW-1:0] LAT_C     = CW'(LAT);
  localparam logic [CW-1:0] LAT_M1    = CW'(LAT-1);
  localparam logic [CW-1:0] TOTAL_M1  = CW'(TOTAL-1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(OUT_PIX-1);

  logic [1:0]    state_reg;
  logic [CW-1:0] in_cnt_reg;
  logic [AW-1:0] rd_addr_reg;
  logic [7:0]    mem [0:(1<<AW)-1];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_load;
  logic          rd_hs;

  // Captured pixels land at their offset past the warm-up region.
  assign wr_en   = (state_reg == CAPT) && in_valid;
  assign wr_addr = AW'(in_cnt_reg - LAT_C);

  // A read is launched whenever the output register is empty while draining.
  assign rd_load = (state_reg == DRAIN) && !rd_valid;
  assign rd_hs   = (state_reg == DRAIN) && rd_valid && rd_ready;

  assign busy = (state_reg != IDLE);

  // Frame store write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= pixel_in;
    end
  end

  // Registered read port: one-cycle latency from rd_addr to rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 8'd0;
    end else if (rd_load) begin
      rd_data <= mem[rd_addr_reg];
    end
  end

  // Frame sequencing: skip warm-up, capture, then drain one word per handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      in_cnt_reg  <= '0;
      rd_addr_reg <= '0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      done        <= 1'b0;
      cycle_cnt   <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= SKIP;
            in_cnt_reg <= '0;
            cycle_cnt  <= 32'd0;
          end
        end
        SKIP: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (in_valid) begin
            in_cnt_reg <= in_cnt_reg + 1'b1;
            if (in_cnt_reg == LAT_M1) begin
              state_reg <= CAPT;
            end
          end
        end
        CAPT: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (in_valid) begin
            in_cnt_reg <= in_cnt_reg + 1'b1;
            if (in_cnt_reg == TOTAL_M1) begin
              state_reg   <= DRAIN;
              rd_addr_reg <= '0;
            end
          end
        end
        DRAIN: begin
          if (rd_hs) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (rd_addr_reg == LAST_ADDR) begin
              state_reg <= IDLE;
              done      <= 1'b1;
            end else begin
              rd_addr_reg <= rd_addr_reg + 1'b1;
            end
          end else if (!rd_valid) begin
            rd_valid <= 1'b1;
            rd_last  <= (rd_addr_reg == LAST_ADDR);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_frame_sink.sv
// Testbench for median_frame_sink on a 4x4 frame (10 warm-up pixels, 6 drained).
module tb_median_frame_sink;

  localparam int WIDTH   = 4;
  localparam int HEIGHT  = 4;
  localparam int LAT     = 10;
  localparam int TOTAL   = 16;
  localparam int OUT_PIX = 6;
  localparam int AW      = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  pixel_in;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        busy;
  logic        done;
  logic [31:0] cycle_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] frame_pix [TOTAL];

  typedef struct {
    string       name;
    logic [7:0]  base;
    int          gap_mode;
    int          stall_word;
    int          stall_len;
    bit          inject;
    logic [31:0] exp_cyc;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t tab [5];

  median_frame_sink #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .pixel_in (pixel_in),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .busy     (busy),
    .done     (done),
    .cycle_cnt(cycle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Streams frame_pix into the DUT, drains it and checks it against the
  // reference: drained words are frame_pix[LAT..TOTAL-1], the cycle count is
  // the edge number (counted from the start edge) of the final input pixel.
  task automatic run_frame(input string tag, input int gap_mode, input int stall_word,
                           input int stall_len, input bit rand_ready, input bit inject,
                           input bit use_tab, input logic [31:0] tab_cyc,
                           input logic [7:0] tab_first, input logic [7:0] tab_last);
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [31:0] model_cyc;
    logic [7:0]  hold_data;
    int sent;
    int k;
    int dones;
    int stall_left;
    bit hs;
    bit hold;
    bit finished;
    bit v;

    for (int i = LAT; i < TOTAL; i++) exp_q.push_back(frame_pix[i]);

    start = 1'b1;
    tick();
    start = 1'b0;
    sent = 0;
    k = 0;
    model_cyc = 32'd0;
    while (sent < TOTAL) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      pixel_in = v ? frame_pix[sent] : 8'($urandom);
      start    = inject && v && (sent == 12);
      tick();
      k++;
      if (v) begin
        sent++;
        if (sent == TOTAL) model_cyc = 32'(k);
      end
    end
    start    = 1'b0;
    in_valid = inject;
    pixel_in = 8'hFF;

    dones = 0;
    stall_left = stall_len;
    finished = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (rd_valid && got_q.size() == stall_word && stall_left > 0) begin
        rd_ready = 1'b0;
        stall_left--;
        chk($sformatf("%s stall_data", tag), 32'(rd_data), 32'(exp_q[stall_word]));
      end else begin
        rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      hs = rd_valid && rd_ready;
      if (hs) begin
        chk($sformatf("%s rd_last w%0d", tag, got_q.size()), 32'(rd_last),
            32'(got_q.size() == OUT_PIX-1));
        $display("%s: drained word %0d = %02h", tag, got_q.size(), rd_data);
        got_q.push_back(rd_data);
      end
      hold = rd_valid && !rd_ready;
      hold_data = rd_data;
      tick();
      if (done) dones++;
      if (hold) begin
        chk($sformatf("%s valid_hold", tag), 32'(rd_valid), 32'd1);
        chk($sformatf("%s data_hold", tag), 32'(rd_data), 32'(hold_data));
      end
      if (got_q.size() == OUT_PIX) begin
        finished = 1'b1;
        break;
      end
    end
    rd_ready = 1'b1;
    if (!finished) chk($sformatf("%s drain_timeout", tag), 32'(got_q.size()), 32'(OUT_PIX));
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) dones++;
    end
    in_valid = 1'b0;

    chk($sformatf("%s done_count", tag), 32'(dones), 32'd1);
    chk($sformatf("%s busy_end", tag), 32'(busy), 32'd0);
    chk($sformatf("%s rd_valid_end", tag), 32'(rd_valid), 32'd0);
    chk($sformatf("%s cycle_cnt", tag), cycle_cnt, use_tab ? tab_cyc : model_cyc);
    for (int i = 0; i < OUT_PIX; i++) begin
      if (i < got_q.size())
        chk($sformatf("%s word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      else
        chk($sformatf("%s word%0d missing", tag, i), 32'(got_q.size()), 32'(OUT_PIX));
    end
    if (use_tab && got_q.size() == OUT_PIX) begin
      chk($sformatf("%s first", tag), 32'(got_q[0]), 32'(tab_first));
      chk($sformatf("%s last", tag), 32'(got_q[OUT_PIX-1]), 32'(tab_last));
    end
    $display("%s: frame complete, %0d words, cycle_cnt=%0d", tag, got_q.size(), cycle_cnt);
  endtask

  initial begin
    tab[0] = '{"b2b",       8'h00, 0, -1, 0, 1'b0, 32'd16, 8'h0A, 8'h0F};
    tab[1] = '{"gapped",    8'h00, 1, -1, 0, 1'b0, 32'd31, 8'h0A, 8'h0F};
    tab[2] = '{"backpress", 8'h00, 0,  2, 5, 1'b0, 32'd16, 8'h0A, 8'h0F};
    tab[3] = '{"ignored",   8'h00, 0, -1, 0, 1'b1, 32'd16, 8'h0A, 8'h0F};
    tab[4] = '{"gap_stall", 8'h40, 1,  4, 3, 1'b0, 32'd31, 8'h4A, 8'h4F};

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    pixel_in = 8'h00;
    rd_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset cycle_cnt", cycle_cnt, 32'd0);
    chk("reset rd_last", 32'(rd_last), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    $display("reset: idle state observed");

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < TOTAL; i++) frame_pix[i] = 8'(tab[t].base + i);
      run_frame(tab[t].name, tab[t].gap_mode, tab[t].stall_word, tab[t].stall_len,
                1'b0, tab[t].inject, 1'b1, tab[t].exp_cyc, tab[t].exp_first, tab[t].exp_last);
    end

    // Abort a frame at in_cnt=12, then run a fresh one.
    for (int i = 0; i < TOTAL; i++) frame_pix[i] = 8'(8'h80 + i);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      pixel_in = frame_pix[i];
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort cycle_cnt", cycle_cnt, 32'd0);
    chk("abort rd_valid", 32'(rd_valid), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort no_done", 32'(done), 32'd0);
      chk("abort idle", 32'(busy), 32'd0);
    end
    $display("abort: frame aborted at in_cnt=12");
    for (int i = 0; i < TOTAL; i++) frame_pix[i] = 8'(8'h20 + i);
    run_frame("refill", 0, -1, 0, 1'b0, 1'b0, 1'b1, 32'd16, 8'h2A, 8'h2F);

    // Randomised frames against the reference.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < TOTAL; i++) frame_pix[i] = 8'($urandom);
      run_frame($sformatf("rand%0d", r), 2, int'($urandom_range(0, OUT_PIX-1)),
                int'($urandom_range(0, 4)), 1'b1, 1'($urandom_range(0, 1)),
                1'b0, 32'd0, 8'h00, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
